// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the DDS tuning word from f_start to f_stop,
// holding each word for dwell+1 cycles, as a single up-sweep or a triangle sweep.
module dds_sweep_ctrl #(
  parameter int unsigned FW = 32,
  parameter int unsigned DW = 16
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          start,
  input  logic          abort,
  input  logic          mode,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  output logic [FW-1:0] freq_word,
  output logic          step_stb,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  typedef enum logic {ST_IDLE = 1'b0, ST_DWELL = 1'b1} state_t;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  state_t        state_q, state_nxt;
  logic          dir_q, dir_nxt;
  logic [DW-1:0] cnt_q, cnt_nxt;

  logic          mode_q;
  logic [FW-1:0] f_start_q, f_stop_q, f_step_q;
  logic [DW-1:0] dwell_q;

  logic [FW-1:0] freq_nxt;
  logic          stb_nxt, busy_nxt, done_nxt, err_nxt;
  logic          load;
  logic [FW-1:0] load_word;

  logic          cfg_ok, cfg_ld;
  logic          at_stop, at_start, dwell_end;
  logic [FW:0]   up_sum;
  logic [FW-1:0] up_word, dn_diff, dn_word;

  assign cfg_ok    = (f_step != '0) && (f_start <= f_stop);
  assign cfg_ld    = (state_q == ST_IDLE) && start && !abort;
  assign at_stop   = (freq_word == f_stop_q);
  assign at_start  = (freq_word == f_start_q);
  assign dwell_end = (cnt_q == '0);

  // Saturating steps: sum carries an extra bit, down step checks headroom first
  assign up_sum  = {1'b0, freq_word} + {1'b0, f_step_q};
  assign up_word = (up_sum > {1'b0, f_stop_q}) ? f_stop_q : up_sum[FW-1:0];
  assign dn_diff = freq_word - f_start_q;
  assign dn_word = (dn_diff < f_step_q) ? f_start_q : (freq_word - f_step_q);

  // State and datapath registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_UP;
      cnt_q     <= '0;
      freq_word <= '0;
      step_stb  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      mode_q    <= 1'b0;
      f_start_q <= '0;
      f_stop_q  <= '0;
      f_step_q  <= '0;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_nxt;
      dir_q     <= dir_nxt;
      cnt_q     <= cnt_nxt;
      freq_word <= freq_nxt;
      step_stb  <= stb_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      cfg_err   <= err_nxt;
      if (cfg_ld) begin
        mode_q    <= mode;
        f_start_q <= f_start;
        f_stop_q  <= f_stop;
        f_step_q  <= f_step;
        dwell_q   <= dwell;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort && cfg_ok) state_nxt = ST_DWELL;
      end
      ST_DWELL: begin
        if (abort) state_nxt = ST_IDLE;
        else if (dwell_end && (dir_q == DIR_UP) && at_stop && !mode_q) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    freq_nxt  = freq_word;
    stb_nxt   = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    cnt_nxt   = cnt_q;
    dir_nxt   = dir_q;
    load      = 1'b0;
    load_word = freq_word;
    busy_nxt  = (state_nxt == ST_DWELL);
    if (!abort) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (!cfg_ok) begin
              err_nxt = 1'b1;
            end else begin
              freq_nxt = f_start;
              stb_nxt  = 1'b1;
              cnt_nxt  = dwell;
              dir_nxt  = DIR_UP;
            end
          end
        end
        ST_DWELL: begin
          if (!dwell_end) begin
            cnt_nxt = cnt_q - DW'(1);
          end else if (dir_q == DIR_UP) begin
            if (!at_stop) begin
              load      = 1'b1;
              load_word = up_word;
            end else if (!mode_q) begin
              done_nxt = 1'b1;
            end else begin
              dir_nxt   = DIR_DN;
              load      = 1'b1;
              load_word = dn_word;
            end
          end else begin
            load = 1'b1;
            if (!at_start) begin
              load_word = dn_word;
            end else begin
              dir_nxt   = DIR_UP;
              load_word = up_word;
            end
          end
        end
        default: ;
      endcase
    end
    if (load) begin
      freq_nxt = load_word;
      stb_nxt  = 1'b1;
      cnt_nxt  = dwell_q;
    end
  end

endmodule
